// File: rtl/boot_word_asm.sv
// Boot loader byte-to-word assembler: parses a framed UART byte stream and issues
// little-endian 32-bit word writes toward a TCM through a valid/ready write port.
module boot_word_asm #(
  parameter logic [7:0]  ONbyte    = 8'hAA,
  parameter logic [7:0]  STPbyte   = 8'h55,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output logic        boot_active,
  output logic        done,
  output logic        err_frame,
  output logic        err_overrun
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, STOP, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] addr_q, addr_d;
  logic        word_done_q, word_done_d;
  logic        wr_valid_q, wr_valid_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        boot_active_q, boot_active_d;
  logic        done_q, done_d;
  logic        err_frame_q, err_frame_d;
  logic        err_overrun_q, err_overrun_d;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. STOP is entered on the last data byte itself, so a stop
  // byte arriving right behind it is never mistaken for data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (rx_valid && rx_data == ONbyte) state_d = LEN0;
      LEN0:  if (rx_valid) state_d = LEN1;
      LEN1:  if (rx_valid) state_d = ({rx_data, len_lo_q} == 16'd0) ? STOP : DATA;
      DATA:  if (rx_valid && byte_cnt_q == 2'd3 && cnt_q == 16'd1) state_d = STOP;
      STOP:  if (rx_valid) state_d = DRAIN;
      DRAIN: if (!wr_valid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    len_lo_d      = len_lo_q;
    cnt_d         = cnt_q;
    byte_cnt_d    = byte_cnt_q;
    asm_d         = asm_q;
    addr_d        = addr_q;
    word_done_d   = 1'b0;
    wr_valid_d    = wr_valid_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    boot_active_d = boot_active_q;
    done_d        = 1'b0;
    err_frame_d   = err_frame_q;
    err_overrun_d = err_overrun_q;

    case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == ONbyte) begin
          boot_active_d = 1'b1;
          err_frame_d   = 1'b0;
          err_overrun_d = 1'b0;
          addr_d        = BASE_ADDR;
          byte_cnt_d    = 2'd0;
        end
      end
      LEN0: if (rx_valid) len_lo_d = rx_data;
      LEN1: begin
        if (rx_valid) begin
          cnt_d      = {rx_data, len_lo_q};
          byte_cnt_d = 2'd0;
        end
      end
      DATA: begin
        if (rx_valid) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            word_done_d = 1'b1;
            cnt_d       = cnt_q - 16'd1;
          end
        end
      end
      STOP: if (rx_valid && rx_data != STPbyte) err_frame_d = 1'b1;
      DRAIN: begin
        if (!wr_valid_q) begin
          done_d        = ~err_frame_q;
          boot_active_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (wr_valid_q && wr_ready) wr_valid_d = 1'b0;

    // A completed word replaces the pending one only if that one leaves this cycle
    if (word_done_q) begin
      addr_d = addr_q + 32'd4;
      if (wr_valid_q && !wr_ready) begin
        err_overrun_d = 1'b1;
      end else begin
        wr_valid_d = 1'b1;
        wr_addr_d  = addr_q;
        wr_data_d  = asm_q;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      len_lo_q      <= 8'd0;
      cnt_q         <= 16'd0;
      byte_cnt_q    <= 2'd0;
      asm_q         <= 32'd0;
      addr_q        <= 32'd0;
      word_done_q   <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= 32'd0;
      wr_data_q     <= 32'd0;
      boot_active_q <= 1'b0;
      done_q        <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      len_lo_q      <= len_lo_d;
      cnt_q         <= cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      addr_q        <= addr_d;
      word_done_q   <= word_done_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      boot_active_q <= boot_active_d;
      done_q        <= done_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_strb     = wr_valid_q ? 4'hF : 4'h0;
  assign boot_active = boot_active_q;
  assign done        = done_q;
  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_boot_word_asm.sv
// Scoreboard bench for boot_word_asm: directed frames plus random frames against
// a frame-level reference model of the expected word writes and flags.
module tb_boot_word_asm;
  localparam logic [31:0] TB_BASE = 32'h0000_0000;
  localparam logic [7:0]  ON_B    = 8'hAA;
  localparam logic [7:0]  STP_B   = 8'h55;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        boot_active;
  logic        done;
  logic        err_frame;
  logic        err_overrun;

  always #5 Clk = ~Clk;

  boot_word_asm #(.ONbyte(ON_B), .STPbyte(STP_B), .BASE_ADDR(TB_BASE)) dut (
    .Clk(Clk), .Rst(Rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .boot_active(boot_active), .done(done),
    .err_frame(err_frame), .err_overrun(err_overrun)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ready_mode = 1;      // 0 random with bounded stall, 1 always ready, 2 held low
  int hold_lo_at = -1;
  int hold_hi_at = -1;
  logic [63:0] exp_q[$];   // {addr, data}
  logic [7:0]  frm[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted write is popped from the scoreboard and compared
  always @(negedge Clk) begin
    if (!Rst) begin
      if (done) done_cnt++;
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write", wr_addr, wr_data);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          $display("write addr 0x%08h data 0x%08h strb %h", wr_addr, wr_data, wr_strb);
          chk("wr_addr", wr_addr, e[63:32]);
          chk("wr_data", wr_data, e[31:0]);
          chk("wr_strb", 32'(wr_strb), 32'hF);
        end
      end
    end
  end

  int stall = 0;
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #2;
      case (ready_mode)
        0: begin
          if (wr_valid && !wr_ready) stall++;
          else stall = 0;
          wr_ready = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        1: wr_ready = 1'b1;
        default: wr_ready = 1'b0;
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge Clk);
    @(posedge Clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge Clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap, input bit chk_active);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == hold_lo_at) ready_mode = 2;
      if (i == hold_hi_at) ready_mode = 1;
      send_byte(frm[i], gap);
      if (chk_active) chk("boot_active_in_frame", 32'(boot_active), 32'd1);
    end
  endtask

  task automatic finish_frame(input string nm, input int d0, input int exp_done,
                              input bit ef, input bit ov);
    int t = 0;
    while (boot_active && t < 400) begin
      @(negedge Clk);
      t++;
    end
    chk({nm, "_idle_bound"}, 32'(t < 400), 32'd1);
    repeat (2) @(posedge Clk);
    #1;
    chk({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'(exp_done));
    chk({nm, "_err_frame"}, 32'(err_frame), 32'(ef));
    chk({nm, "_err_overrun"}, 32'(err_overrun), 32'(ov));
    chk({nm, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_boot_active_low"}, 32'(boot_active), 32'd0);
    $display("frame %s finished: done %0d err_frame %0b err_overrun %0b", nm,
             done_cnt - d0, err_frame, err_overrun);
    exp_q.delete();
  endtask

  // Reference model: a frame of n random words, expected writes at consecutive word addresses
  task automatic make_frame(input int n, input bit bad_stop);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] n16;
    n16 = 16'(n);
    frm.delete();
    frm.push_back(ON_B);
    frm.push_back(n16[7:0]);
    frm.push_back(n16[15:8]);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 7))
          0: b = ON_B;
          1: b = STP_B;
          default: b = 8'($urandom_range(0, 255));
        endcase
        w[8*k +: 8] = b;
        frm.push_back(b);
      end
      exp_q.push_back({TB_BASE + 32'(4 * i), w});
    end
    if (bad_stop) begin
      b = 8'($urandom_range(0, 255));
      if (b == STP_B) b = 8'h56;
      frm.push_back(b);
    end else begin
      frm.push_back(STP_B);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    bit bad;
    Rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_wr_strb", 32'(wr_strb), 32'd0);
    chk("rst_boot_active", 32'(boot_active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err_frame", 32'(err_frame), 32'd0);
    chk("rst_err_overrun", 32'(err_overrun), 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Stray bytes before a start byte are ignored
    d0 = done_cnt;
    frm = '{8'h13, 8'h55, 8'h00};
    for (int i = 0; i < 3; i++) begin
      send_byte(frm[i], 2);
      chk("stray_boot_active", 32'(boot_active), 32'd0);
    end
    repeat (5) @(posedge Clk); #1;
    chk("stray_done", 32'(done_cnt - d0), 32'd0);

    // One word, always ready
    d0 = done_cnt;
    frm = '{8'hAA, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_q.push_back({32'h0, 32'h4433_2211});
    send_frame(3, 1);
    finish_frame("one_word", d0, 1, 1'b0, 1'b0);

    // Start/stop values as data, then a wrong stop byte
    d0 = done_cnt;
    frm = '{8'hAA, 8'h01, 8'h00, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h13};
    exp_q.push_back({32'h0, 32'hAA55_AA55});
    send_frame(3, 1);
    finish_frame("bad_stop", d0, 0, 1'b1, 1'b0);

    // Zero-length frame
    d0 = done_cnt;
    frm = '{8'hAA, 8'h00, 8'h00, 8'h55};
    send_frame(3, 1);
    finish_frame("zero_len", d0, 1, 1'b0, 1'b0);

    // Overrun: ready low across the second word; third word lands at +8
    d0 = done_cnt;
    frm = '{8'hAA, 8'h03, 8'h00,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h55};
    exp_q.push_back({32'h0, 32'h0403_0201});
    exp_q.push_back({32'h8, 32'h0C0B_0A09});
    hold_lo_at = 6;
    hold_hi_at = 12;
    send_frame(4, 1);
    hold_lo_at = -1;
    hold_hi_at = -1;
    ready_mode = 1;
    finish_frame("overrun", d0, 1, 1'b0, 1'b1);

    // Reset mid-frame abandons it; the next frame writes at the base address
    frm = '{8'hAA, 8'h01, 8'h00, 8'h11, 8'h22};
    send_frame(2, 1);
    @(posedge Clk); #1;
    Rst = 1'b1;
    repeat (2) @(posedge Clk); #1;
    Rst = 1'b0;
    chk("midrst_boot_active", 32'(boot_active), 32'd0);
    chk("midrst_wr_valid", 32'(wr_valid), 32'd0);
    d0 = done_cnt;
    frm = '{8'hAA, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55};
    exp_q.push_back({32'h0, 32'hEFBE_ADDE});
    send_frame(2, 1);
    finish_frame("after_reset", d0, 1, 1'b0, 1'b0);

    // Tightly spaced bytes with a ready sink
    d0 = done_cnt;
    make_frame(3, 1'b0);
    send_frame(0, 1);
    finish_frame("tight", d0, 1, 1'b0, 1'b0);

    // Random frames with random backpressure
    ready_mode = 0;
    for (int f = 0; f < 20; f++) begin
      d0 = done_cnt;
      n = $urandom_range(0, 6);
      bad = ($urandom_range(0, 4) == 0);
      make_frame(n, bad);
      send_frame($urandom_range(8, 12), 1);
      finish_frame($sformatf("rand%0d", f), d0, bad ? 0 : 1, bad, 1'b0);
    end
    ready_mode = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
